// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises the line, samples mid-bit from the baud prescaler's
// half pulse, checks the stop bit and holds each byte in a single-entry valid/ready register.
//
// state     | meaning
// IDLE      | line high, prescaler held cleared, waiting for a start edge
// START     | validating the start bit at mid-bit, waiting for end of start bit
// DATA      | sampling DataBits data bits, LSB first
// STOP      | sampling the stop bit
// WAIT_HIGH | framing error or break, waiting for the line to return high
module uart_rx_deframer #(
  parameter int DataBits   = 8,
  parameter int SyncStages = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rx,
  input  logic                i_strobe,
  input  logic                i_half,
  output logic                o_baud_en,
  output logic                o_baud_clr,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_frame_err,
  output logic                o_overrun,
  output logic                o_busy
);

  localparam int CntW = $clog2(DataBits + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t              state;
  logic [SyncStages-1:0] sync_q;
  logic                rx_s;
  logic [DataBits-1:0] shift_q;
  logic [CntW-1:0]     bit_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SyncStages-2:0], i_rx};
  end

  assign rx_s = sync_q[SyncStages-1];

  // Prescaler runs only while a frame is in flight so it restarts from 0 at each start bit.
  assign o_baud_clr = (state == IDLE) || (state == WAIT_HIGH);
  assign o_baud_en  = ~o_baud_clr;
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      shift_q     <= '0;
      bit_cnt     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) state <= START;
        end
        START: begin
          if (i_half && rx_s) begin
            state <= IDLE;
          end else if (i_strobe) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (i_half) shift_q <= {rx_s, shift_q[DataBits-1:1]};
          if (i_strobe) begin
            bit_cnt <= bit_cnt + CntW'(1);
            if (bit_cnt == CntW'(DataBits - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (i_half) begin
            if (rx_s) begin
              o_data    <= shift_q;
              o_valid   <= 1'b1;
              o_overrun <= o_valid && !i_ready;
              state     <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer with a divide-by-16 prescaler model.
module tb_uart_rx_deframer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic       strobe, half;
  logic       o_baud_en, o_baud_clr, o_valid, o_frame_err, o_overrun, o_busy;
  logic [7:0] o_data;
  logic [3:0] pcnt;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int busy_cycles = 0;
  logic [7:0] ovr_data = 8'h00;
  logic [7:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  uart_rx_deframer #(.DataBits(8), .SyncStages(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .i_strobe(strobe), .i_half(half),
    .o_baud_en(o_baud_en), .o_baud_clr(o_baud_clr), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  // Prescaler: cleared by reset or o_baud_clr; half at count 7, strobe at count 15.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           pcnt <= 4'd0;
    else if (o_baud_clr) pcnt <= 4'd0;
    else if (o_baud_en)  pcnt <= pcnt + 4'd1;
  end
  assign half   = o_baud_en && (pcnt == 4'd7);
  assign strobe = o_baud_en && (pcnt == 4'd15);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_busy) busy_cycles++;
      if (o_frame_err) ferr_cnt++;
      if (o_overrun) begin
        ovr_cnt++;
        ovr_data = o_data;
      end
      if (o_valid && i_ready) begin
        accept_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h, required no word", o_data);
        end else begin
          chk("rx_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (16) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, f0, o0;
    repeat (3) tick();
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_baud_en", {31'd0, o_baud_en}, 32'd0);
    chk("reset_baud_clr", {31'd0, o_baud_clr}, 32'd1);
    chk("reset_data", {24'd0, o_data}, 32'd0);
    i_rst = 1'b0;
    repeat (10) tick();

    // Basic frame
    a0 = accept_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (4) tick();
    chk("basic_accepts", accept_cnt - a0, 32'd1);
    chk("basic_ferr", ferr_cnt - f0, 32'd0);
    chk("basic_busy_idle", {31'd0, o_busy}, 32'd0);
    chk("basic_valid_clear", {31'd0, o_valid}, 32'd0);

    // Back-to-back frames
    a0 = accept_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) tick();
    chk("b2b_accepts", accept_cnt - a0, 32'd2);
    chk("b2b_ferr", ferr_cnt - f0, 32'd0);
    chk("b2b_ovr", ovr_cnt - o0, 32'd0);

    // False start
    a0 = accept_cnt; busy_cycles = 0;
    i_rx = 1'b0;
    repeat (4) tick();
    i_rx = 1'b1;
    repeat (30) tick();
    chk("false_accepts", accept_cnt - a0, 32'd0);
    chk("false_busy_seen", {31'd0, busy_cycles > 0}, 32'd1);
    chk("false_busy_short", {31'd0, busy_cycles < 16}, 32'd1);
    chk("false_busy_end", {31'd0, o_busy}, 32'd0);

    // Framing error followed by break
    a0 = accept_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) tick();
    chk("ferr_pulses", ferr_cnt - f0, 32'd1);
    chk("ferr_hold_busy", {31'd0, o_busy}, 32'd1);
    chk("ferr_hold_baud_en", {31'd0, o_baud_en}, 32'd0);
    chk("ferr_no_word", accept_cnt - a0, 32'd0);
    i_rx = 1'b1;
    repeat (6) tick();
    chk("ferr_release_idle", {31'd0, o_busy}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (4) tick();
    chk("ferr_next_accepts", accept_cnt - a0, 32'd1);

    // Overrun
    a0 = accept_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) tick();
    chk("ovr_pulses", ovr_cnt - o0, 32'd1);
    chk("ovr_data_at_pulse", {24'd0, ovr_data}, 32'h22);
    chk("ovr_valid_held", {31'd0, o_valid}, 32'd1);
    chk("ovr_data", {24'd0, o_data}, 32'h22);
    chk("ovr_no_accept", accept_cnt - a0, 32'd0);
    exp_q.push_back(8'h22);
    i_ready = 1'b1;
    tick();
    chk("ovr_valid_cleared", {31'd0, o_valid}, 32'd0);
    chk("ovr_one_accept", accept_cnt - a0, 32'd1);
    chk("ovr_ferr", ferr_cnt - f0, 32'd0);

    // Reset during data bit 3
    a0 = accept_cnt;
    i_rx = 1'b0;
    repeat (16) tick();
    i_rx = 1'b0; repeat (16) tick();
    i_rx = 1'b1; repeat (16) tick();
    i_rx = 1'b0; repeat (16) tick();
    i_rx = 1'b1; repeat (8) tick();
    chk("rst_pre_busy", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_baud_en", {31'd0, o_baud_en}, 32'd0);
    chk("rst_baud_clr", {31'd0, o_baud_clr}, 32'd1);
    chk("rst_ferr_ovr", {30'd0, o_frame_err, o_overrun}, 32'd0);
    i_rx = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    repeat (20) tick();
    chk("rst_no_word", accept_cnt - a0, 32'd0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (4) tick();
    chk("rst_next_accepts", accept_cnt - a0, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
